farm_sensor_conditioner: RTL
============================

# farm_sensor_conditioner

Conditions the raw farm-road vehicle detector before it reaches the traffic-light controller FSM. The block synchronises the asynchronous detector input, debounces it with a cycle counter, and latches a pending farm request so that a brief vehicle presence during highway green is not lost. Its `farmSensor` output drives the FSM's `farmSensor` input directly. It observes the FSM's `farmSignal` output so that the pending request is released once the farm road is served.

## Interface
- `SYNC_STAGES`, default 2: synchroniser flop depth; must be ≥2.
- `DEBOUNCE_CYCLES`, default 5_000_000: consecutive cycles the new level must hold before it is accepted (100 ms at 50 MHz); must be ≥1.
- `CNT_W`, default 23: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports (name, direction, width, meaning):
- `Clk`  in  1  system clock, 50 MHz.
- `Rst`  in  1  synchronous, active-low reset; one clock.
- `sensorRaw`  in  1  asynchronous detector contact; 1 = vehicle present.
- `farmSignal`  in  2  farm light colour from the FSM, using the shared RED/YELLOW/GREEN codes.
- `farmSensor`  out  1  conditioned request to the FSM.
- `sensorStable`  out  1  debounced detector level.
- `sensorRise`  out  1  one-cycle pulse on a debounced 0→1 transition.

## Operation
- **Synchroniser:** `SYNC_STAGES` flops clocked by `Clk`. The last stage is `syncOut`.
- **Debounce FSM:** two states, `LOW` (`sensorStable`=0) and `HIGH` (`sensorStable`=1).
  - While `syncOut` equals the current level, the counter holds 0.
  - While they differ, the counter increments each cycle.
  - On a cycle where the levels differ and the counter equals `DEBOUNCE_CYCLES-1`:
    - the state toggles;
    - the counter returns to 0;
    - on a LOW→HIGH toggle, `sensorRise` pulses for that next cycle.
  - Any cycle where `syncOut` matches the current level again resets the counter to 0. A glitch shorter than `DEBOUNCE_CYCLES` therefore produces no change.
  - The counter never exceeds `DEBOUNCE_CYCLES-1`, so it cannot wrap.
- **Request latch `pending`:**
  - Set when `sensorRise`=1 and `farmSignal`≠GREEN.
  - Cleared when `farmSignal`==GREEN.
  - If set and clear conditions coincide, clear wins.
- **Output:** `farmSensor` = `sensorStable` OR `pending`, registered.
  - During farm green, `farmSensor` follows the live debounced level. This lets the FSM end farm green early once the road empties.
  - Outside farm green, a vehicle that arrived and left still holds the request.
- **Reset** (`Rst`=0 at a `Clk` edge):
  - all synchroniser flops, counter, state, `pending` and every output are set to 0;
  - reset has priority over all other updates, including a debounce in progress.

## Timing
- All outputs are registered. No combinational path runs from any input to any output.
- Take `sensorRaw` stable high before edge e1. Then:
  - `syncOut`=1 after edge e(SYNC_STAGES);
  - `sensorStable`=1 and `sensorRise`=1 after edge e(SYNC_STAGES+DEBOUNCE_CYCLES);
  - `farmSensor`=1 one edge later.
- The falling path has the same latency. `sensorRise` does not pulse on a falling transition.
- `pending` clears on the first edge that samples `farmSignal`==GREEN. `farmSensor` reflects the clear one edge later.
- A `sensorRaw` pulse shorter than `DEBOUNCE_CYCLES` cycles, measured at `syncOut`, is fully rejected.

## Structure
- Shared package `tlc_pkg` holds:
  - the colour codes RED=2'b01, YELLOW=2'b10, GREEN=2'b11;
  - the FSM state encodings S0–S5;
  - the 50 MHz timing constants (1 s, 3 s, 15 s, 30 s counts).

  The controller FSM and this block both import it.
- One sub-module, `sync_ff`: a parameterised N-stage synchroniser. It is instantiated once here and is reusable by other asynchronous inputs.
- The debounce counter, state, latch and output register live in `farm_sensor_conditioner` itself.

## Test plan
All scenarios use `SYNC_STAGES`=2 and `DEBOUNCE_CYCLES`=4.
- **Reset:** hold `Rst`=0 for 3 cycles with `sensorRaw`=1 → all outputs are 0 throughout. After release, `sensorStable` rises exactly 6 edges later and `farmSensor` 7 edges later.
- **Glitch reject:** with `farmSignal`=GREEN, drive `sensorRaw`=1 for 3 cycles, then 0 → `sensorStable`, `sensorRise` and `farmSensor` stay 0, and the counter returns to 0.
- **Latch hold:** with `farmSignal`=GREEN, drive `sensorRaw`=1 for 10 cycles, then 0 → `sensorRise` pulses once and `pending` stays 0. Now switch `farmSignal`=RED and repeat → `farmSensor` stays 1 after `sensorStable` drops. It clears 2 edges after `farmSignal` becomes GREEN, provided the sensor is low.
- **Live during green:** `pending`=1, `farmSignal`=GREEN, `sensorRaw` high → `farmSensor` stays 1. Drop `sensorRaw` → `farmSensor` is 0 exactly 7 edges later.
- **Simultaneous:** `farmSignal` becomes GREEN on the same edge that `sensorRise` asserts → `pending` stays 0.
- **Reset mid-debounce:** assert `Rst`=0 while the counter is at 2 → the counter, state and outputs are 0 on the next edge. No `sensorRise` occurs before the full debounce restarts.

Source files
------------

// File: rtl/tlc_pkg.sv
// Definitions shared by the traffic-light controller and its input conditioners:
// light colour codes, controller state encodings and 50 MHz timing counts.
package tlc_pkg;

  localparam logic [1:0] RED    = 2'b01;
  localparam logic [1:0] YELLOW = 2'b10;
  localparam logic [1:0] GREEN  = 2'b11;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5
  } tlc_state_t;

  localparam int unsigned CLK_HZ    = 50_000_000;
  localparam int unsigned CYCLES_1S  = CLK_HZ;
  localparam int unsigned CYCLES_3S  = 3 * CLK_HZ;
  localparam int unsigned CYCLES_15S = 15 * CLK_HZ;
  localparam int unsigned CYCLES_30S = 30 * CLK_HZ;

  typedef enum logic {
    StLow  = 1'b0,
    StHigh = 1'b1
  } deb_state_t;

endpackage

// File: rtl/sync_ff.sv
// N-stage flop synchroniser for a single asynchronous input.
// Synchronous active-low reset clears every stage.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/farm_sensor_conditioner.sv
// Synchronises and debounces the farm-road detector, and holds a pending request
// until the farm road is served with a green light.
module farm_sensor_conditioner
  import tlc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 5_000_000,
  parameter int unsigned CNT_W           = 23
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       sensorRaw,
  input  logic [1:0] farmSignal,
  output logic       farmSensor,
  output logic       sensorStable,
  output logic       sensorRise
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             w_sync_out;
  deb_state_t       r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic             r_rise, w_rise_d;
  logic             r_pending, w_pending_d;
  logic             r_farm_sensor, w_farm_sensor_d;
  logic             w_differ;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync_ff (
    .i_clk   (Clk),
    .i_rst_n (Rst),
    .i_d     (sensorRaw),
    .o_q     (w_sync_out)
  );

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_state       <= StLow;
      r_cnt         <= '0;
      r_rise        <= 1'b0;
      r_pending     <= 1'b0;
      r_farm_sensor <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_cnt         <= w_cnt_d;
      r_rise        <= w_rise_d;
      r_pending     <= w_pending_d;
      r_farm_sensor <= w_farm_sensor_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = '0;
    w_rise_d  = 1'b0;
    w_differ  = (w_sync_out != (r_state == StHigh));
    if (w_differ) begin
      if (r_cnt == CntMax) begin
        w_state_d = (r_state == StHigh) ? StLow : StHigh;
        w_rise_d  = (r_state == StLow);
      end else begin
        w_cnt_d = r_cnt + 1'b1;
      end
    end
    // Serving the farm road releases the request, even on the cycle a new rise arrives.
    w_pending_d     = (farmSignal == GREEN) ? 1'b0 : (r_pending | r_rise);
    w_farm_sensor_d = (r_state == StHigh) | r_pending;
  end

  assign sensorStable = (r_state == StHigh);
  assign sensorRise   = r_rise;
  assign farmSensor   = r_farm_sensor;

endmodule
